// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, external)
// and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_last;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_last,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_last,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between CPU and external requester with bounded bursts.
// Define DMEM_ARB_RR_EN for round-robin fairness; default is fixed CPU priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_EXT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic              cpu_beat_s;
  logic              ext_beat_s;
  logic              burst_full_s;
  logic              cpu_rvalid_r;
  logic              ext_rvalid_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] ext_rdata_r;
`ifdef DMEM_ARB_RR_EN
  logic              last_ext_r;
`endif

  assign cpu_beat_s   = (state_r == OWN_CPU) && bus.cpu_req;
  assign ext_beat_s   = (state_r == OWN_EXT) && bus.ext_req;
  // True when the beat in progress is the MAX_BURST-th of this tenure
  assign burst_full_s = (beat_cnt_r >= CNT_W'(MAX_BURST - 1));

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cpu_req && bus.ext_req) begin
`ifdef DMEM_ARB_RR_EN
          state_nxt_s = last_ext_r ? OWN_CPU : OWN_EXT;
`else
          state_nxt_s = OWN_CPU;
`endif
        end else if (bus.cpu_req) begin
          state_nxt_s = OWN_CPU;
        end else if (bus.ext_req) begin
          state_nxt_s = OWN_EXT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN_CPU: begin
        if (!bus.cpu_req) begin
          state_nxt_s = bus.ext_req ? OWN_EXT : IDLE;
`ifdef DMEM_ARB_RR_EN
        end else if (burst_full_s && bus.ext_req) begin
          state_nxt_s = OWN_EXT;
`endif
        end else begin
          state_nxt_s = OWN_CPU;
        end
      end
      OWN_EXT: begin
        if (!bus.ext_req || bus.ext_last || (burst_full_s && bus.cpu_req)) begin
          state_nxt_s = bus.cpu_req ? OWN_CPU : IDLE;
        end else begin
          state_nxt_s = OWN_EXT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and per-tenure beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      beat_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        beat_cnt_r <= '0;
      end else if ((cpu_beat_s || ext_beat_s) && (beat_cnt_r < CNT_W'(MAX_BURST))) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Owner of the most recent tenure, consulted on simultaneous requests
  always_ff @(posedge clk) begin
    if (reset) begin
      last_ext_r <= 1'b1;
    end else if (state_r == OWN_CPU) begin
      last_ext_r <= 1'b0;
    end else if (state_r == OWN_EXT) begin
      last_ext_r <= 1'b1;
    end else begin
      last_ext_r <= last_ext_r;
    end
  end
`endif

  // Read strobes one cycle after a read beat; data held between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_r <= 1'b0;
      ext_rvalid_r <= 1'b0;
      cpu_rdata_r  <= '0;
      ext_rdata_r  <= '0;
    end else begin
      cpu_rvalid_r <= cpu_beat_s && !bus.cpu_we;
      ext_rvalid_r <= ext_beat_s && !bus.ext_we;
      if (cpu_rvalid_r) cpu_rdata_r <= bus.mem_rdata;
      else              cpu_rdata_r <= cpu_rdata_r;
      if (ext_rvalid_r) ext_rdata_r <= bus.mem_rdata;
      else              ext_rdata_r <= ext_rdata_r;
    end
  end

  assign bus.cpu_gnt    = (state_r == OWN_CPU);
  assign bus.ext_gnt    = (state_r == OWN_EXT);
  assign bus.cpu_rvalid = cpu_rvalid_r;
  assign bus.ext_rvalid = ext_rvalid_r;

  // Memory returns data in the strobe cycle, so pass it through then
  always_comb begin
    bus.cpu_rdata = cpu_rdata_r;
    bus.ext_rdata = ext_rdata_r;
    if (cpu_rvalid_r) bus.cpu_rdata = bus.mem_rdata;
    else              bus.cpu_rdata = cpu_rdata_r;
    if (ext_rvalid_r) bus.ext_rdata = bus.mem_rdata;
    else              bus.ext_rdata = ext_rdata_r;
  end

  // Memory port follows the owner; CPU drives it unless EXT owns the bus
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (reset) begin
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
    end else if (state_r == OWN_EXT) begin
      bus.mem_we    = ext_beat_s && bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end else begin
      bus.mem_we    = cpu_beat_s && bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (fixed-priority build, MAX_BURST = 4) with a
// synchronous-read memory model attached to the memory port.
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:31];

  // Data memory: cleared during reset, write at end of beat, registered read
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) mem[k] <= 16'h0000;
      bus.mem_rdata <= 16'h0000;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 5'd0; bus.cpu_wdata = 16'h0000;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = 5'd0; bus.ext_wdata = 16'h0000;
    bus.ext_last = 1'b0;

    // reset values
    step(); step(); #1;
    chk("rst_cpu_gnt",    {31'd0, bus.cpu_gnt},    32'd0);
    chk("rst_ext_gnt",    {31'd0, bus.ext_gnt},    32'd0);
    chk("rst_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    chk("rst_ext_rvalid", {31'd0, bus.ext_rvalid}, 32'd0);
    chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    chk("rst_cpu_rdata",  {16'd0, bus.cpu_rdata},  32'd0);
    chk("rst_ext_rdata",  {16'd0, bus.ext_rdata},  32'd0);
    chk("rst_mem_addr",   {27'd0, bus.mem_addr},   32'd0);
    chk("rst_mem_wdata",  {16'd0, bus.mem_wdata},  32'd0);

    // external request while reset is held
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 5'd5; bus.ext_wdata = 16'hFFFF;
    #1;
    chk("rstreq_mem_we_a", {31'd0, bus.mem_we}, 32'd0);
    chk("rstreq_mem_addr", {27'd0, bus.mem_addr}, 32'd0);
    step();
    chk("rstreq_ext_gnt", {31'd0, bus.ext_gnt}, 32'd0);
    chk("rstreq_mem_we_b", {31'd0, bus.mem_we}, 32'd0);
    reset = 1'b0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = 5'd0; bus.ext_wdata = 16'h0000;
    step();
    chk("idle_ext_gnt", {31'd0, bus.ext_gnt}, 32'd0);

    // CPU write 0x1234 to addr 3, then read it back
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 5'd3; bus.cpu_wdata = 16'h1234;
    #1;
    chk("wr_idle_gnt",   {31'd0, bus.cpu_gnt}, 32'd0);
    chk("wr_idle_we",    {31'd0, bus.mem_we},  32'd0);
    step();
    chk("wr_gnt",        {31'd0, bus.cpu_gnt}, 32'd1);
    chk("wr_mem_we",     {31'd0, bus.mem_we},  32'd1);
    chk("wr_mem_addr",   {27'd0, bus.mem_addr}, 32'd3);
    chk("wr_mem_wdata",  {16'd0, bus.mem_wdata}, 32'h1234);
    step();
    bus.cpu_we = 1'b0;
    #1;
    chk("rd_mem_we",     {31'd0, bus.mem_we},     32'd0);
    chk("rd_rvalid_pre", {31'd0, bus.cpu_rvalid}, 32'd0);
    step();
    bus.cpu_req = 1'b0;
    #1;
    chk("rd_rvalid",     {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("rd_rdata",      {16'd0, bus.cpu_rdata},  32'h1234);
    step();
    chk("rd_rvalid_off", {31'd0, bus.cpu_rvalid}, 32'd0);
    chk("rd_rdata_hold", {16'd0, bus.cpu_rdata},  32'h1234);
    chk("rd_gnt_off",    {31'd0, bus.cpu_gnt},    32'd0);

    // simultaneous requests: CPU wins, then direct handover to EXT
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'd3;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 5'd3; bus.ext_last = 1'b0;
    step();
    chk("sim_cpu_gnt",   {31'd0, bus.cpu_gnt}, 32'd1);
    chk("sim_ext_gnt",   {31'd0, bus.ext_gnt}, 32'd0);
    step();
    chk("sim_beat2_gnt", {31'd0, bus.cpu_gnt},    32'd1);
    chk("sim_rvalid1",   {31'd0, bus.cpu_rvalid}, 32'd1);
    step();
    bus.cpu_req = 1'b0;
    #1;
    chk("sim_drop_cgnt", {31'd0, bus.cpu_gnt}, 32'd1);
    chk("sim_drop_egnt", {31'd0, bus.ext_gnt}, 32'd0);
    step();
    chk("sim_ho_egnt",   {31'd0, bus.ext_gnt}, 32'd1);
    chk("sim_ho_cgnt",   {31'd0, bus.cpu_gnt}, 32'd0);
    step();
    bus.ext_req = 1'b0;
    #1;
    chk("sim_ext_rvalid", {31'd0, bus.ext_rvalid}, 32'd1);
    chk("sim_ext_rdata",  {16'd0, bus.ext_rdata},  32'h1234);
    step();
    chk("sim_ext_gnt_off", {31'd0, bus.ext_gnt}, 32'd0);

    // external 4-beat write burst ending on ext_last
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 5'd0; bus.ext_wdata = 16'hA000;
    #1;
    chk("bst_idle_gnt", {31'd0, bus.ext_gnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.ext_addr  = 5'(i);
      bus.ext_wdata = 16'hA000 + 16'(i);
      bus.ext_last  = (i == 3);
      #1;
      chk("bst_gnt",   {31'd0, bus.ext_gnt},   32'd1);
      chk("bst_we",    {31'd0, bus.mem_we},    32'd1);
      chk("bst_addr",  {27'd0, bus.mem_addr},  32'(i));
      chk("bst_wdata", {16'd0, bus.mem_wdata}, 32'hA000 + 32'(i));
    end
    step();
    bus.ext_req = 1'b0; bus.ext_last = 1'b0; bus.ext_we = 1'b0;
    #1;
    chk("bst_end_gnt", {31'd0, bus.ext_gnt}, 32'd0);
    chk("bst_end_we",  {31'd0, bus.mem_we},  32'd0);
    chk("bst_mem2",    {16'd0, mem[2]},      32'hA002);

    // 8-beat external burst preempted by CPU after MAX_BURST beats
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 5'd8; bus.ext_wdata = 16'hB000;
    #1;
    chk("pre_idle_gnt", {31'd0, bus.ext_gnt}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      step();
      bus.ext_addr  = 5'(8 + j);
      bus.ext_wdata = 16'hB000 + 16'(j);
      if (j == 1) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'd2;
      end
      #1;
      chk("pre_ext_gnt", {31'd0, bus.ext_gnt}, 32'd1);
      chk("pre_addr",    {27'd0, bus.mem_addr}, 32'(8 + j));
    end
    step();
    bus.ext_addr = 5'd12; bus.ext_wdata = 16'hB004;
    #1;
    chk("pre_ext_off",  {31'd0, bus.ext_gnt},  32'd0);
    chk("pre_cpu_gnt",  {31'd0, bus.cpu_gnt},  32'd1);
    chk("pre_cpu_addr", {27'd0, bus.mem_addr}, 32'd2);
    chk("pre_cpu_we",   {31'd0, bus.mem_we},   32'd0);
    step();
    bus.cpu_req = 1'b0;
    #1;
    chk("pre_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("pre_cpu_rdata",  {16'd0, bus.cpu_rdata},  32'hA002);
    for (int j = 4; j < 8; j++) begin
      step();
      bus.ext_addr  = 5'(8 + j);
      bus.ext_wdata = 16'hB000 + 16'(j);
      bus.ext_last  = (j == 7);
      #1;
      chk("pre_regain_gnt", {31'd0, bus.ext_gnt}, 32'd1);
      chk("pre_regain_cpu", {31'd0, bus.cpu_gnt}, 32'd0);
      chk("pre_regain_addr", {27'd0, bus.mem_addr}, 32'(8 + j));
    end
    step();
    bus.ext_req = 1'b0; bus.ext_last = 1'b0; bus.ext_we = 1'b0;
    #1;
    chk("pre_end_gnt", {31'd0, bus.ext_gnt}, 32'd0);
    chk("pre_mem11",   {16'd0, mem[11]},     32'hB003);
    chk("pre_mem12",   {16'd0, mem[12]},     32'hB004);
    chk("pre_mem15",   {16'd0, mem[15]},     32'hB007);

    // reset mid-operation: pending read cancelled, write suppressed
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'd3;
    step();
    reset = 1'b1;
    #1;
    chk("mid_rd_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
    step();
    reset = 1'b0;
    bus.cpu_we = 1'b1; bus.cpu_addr = 5'd4; bus.cpu_wdata = 16'h5555;
    #1;
    chk("mid_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    chk("mid_gnt",    {31'd0, bus.cpu_gnt},    32'd0);
    chk("mid_rdata",  {16'd0, bus.cpu_rdata},  32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("mid_wr_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
    chk("mid_wr_we",  {31'd0, bus.mem_we},  32'd0);
    step();
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk("mid_end_gnt", {31'd0, bus.cpu_gnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-port data memory of the 16-bit processor. Shares the memory between the CPU core (register-C store / register-A/B load path) and an external requester (program loader / debug port) using a registered-grant request/grant handshake. Owns mem_we, mem_addr and mem_wdata, returns read data with valid strobes, and bounds burst tenure so neither side starves. Sits between the CPU controller/datapath and data_mem.

## Interface
- ADDR_W, 5, data memory address width (32 words)
- DATA_W, 16, data word width
- MAX_BURST, 4, maximum accesses per tenure while the other side is requesting (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request; held high until accesses are done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU owns memory this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  read data
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external request bundle
- ext_last  in  1  final beat of the external burst
- ext_gnt, ext_rvalid  out  1  external grant, read valid
- ext_rdata  out  DATA_W  read data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after the read address (synchronous read)

## Operation
- FSM states: IDLE, OWN_CPU, OWN_EXT. cpu_gnt = (state==OWN_CPU), ext_gnt = (state==OWN_EXT); both are registered and mutually exclusive.
- Access beat: a cycle with x_gnt & x_req. mem_addr/mem_wdata follow the owner (CPU when not owned by EXT); mem_we = owner_we & owner_req & owner_gnt, and is forced to 0 when reset is high.
- beat_cnt: counts beats in the current tenure, saturates at MAX_BURST, and clears on every state change.
- IDLE: if both requests are high, the winner is CPU under fixed priority (or as set in Configuration). Otherwise the single requester wins, and with no request the FSM stays in IDLE. No access occurs in IDLE.
- OWN_CPU:
  - cpu_req low → OWN_EXT if ext_req is high, else IDLE.
  - Preempted only under the Configuration option.
- OWN_EXT: leave after a beat where
  - ext_last = 1, or
  - beat_cnt reaches MAX_BURST while cpu_req is high.

  Also leave when ext_req drops. Destination is OWN_CPU if cpu_req is high, else IDLE.
- Handover is direct: the new owner's gnt rises in the cycle after the old owner's final beat, with no IDLE bubble.
- last_owner register records the owner of the most recent tenure. It is used only by the Configuration option.

## Timing
- Reset values:
  - state IDLE.
  - cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_we all 0.
  - cpu_rdata, ext_rdata, mem_addr, mem_wdata 0.
  - beat_cnt 0; last_owner = EXT.
- Grant latency: request in cycle N from IDLE → gnt in N+1 → first beat in N+1.
- Read latency: read beat in cycle N → x_rvalid = 1 in N+1, with x_rdata = mem_rdata. rdata holds its value until the next rvalid.
- Write: memory is written at the end of the beat cycle, and no valid strobe is generated.
- A requester may change address/we every beat while gnt is high. Dropping req ends its tenure at that edge.
- Reset mid-operation: a pending rvalid is cancelled, the in-flight write is suppressed, and the FSM returns to IDLE with all grants low.

## Configuration
- DMEM_ARB_RR_EN defined → round-robin fairness:
  - Simultaneous requests in IDLE go to the side ≠ last_owner.
  - OWN_CPU also hands over to OWN_EXT after MAX_BURST CPU beats while ext_req is high. The rules are symmetric.
- Undefined → fixed CPU priority. CPU is never preempted, and last_owner is unused.

## Test plan
- **Reset values:** assert reset 2 cycles → all outputs 0, state IDLE. Then ext_req=1 with reset high → no ext_gnt and mem_we stays 0.
- **CPU write then read:** CPU writes 0x1234 to addr 3, then reads addr 3 → mem_we=1 only on the write beat; cpu_rvalid=1 the cycle after the read beat with cpu_rdata=0x1234.
- **Simultaneous request, fixed priority:** cpu_req and ext_req rise in the same cycle → cpu_gnt next cycle. CPU completes 2 beats and drops req → ext_gnt in the following cycle with no bubble.
- **External burst:** ext writes 0xA000..0xA003 to addrs 0..3, with ext_last on beat 4 and CPU idle → 4 consecutive beats, then IDLE, ext_gnt=0.
- **Preemption of external burst:** ext 8-beat burst, cpu_req raised during beat 2, MAX_BURST=4 → ext_gnt drops after beat 4, cpu_gnt the next cycle. ext regains the grant after cpu_req drops.
- **Round-robin (DMEM_ARB_RR_EN):** CPU requests continuously and ext_req is high → grant switches to ext after 4 CPU beats. A simultaneous request from IDLE after a CPU tenure → ext wins.
